// File: rtl/cube0414_pkg.sv
// Shared constants and types for the CUBE0414 host-side SPI link.
package cube0414_pkg;

  localparam logic [7:0] CUBE0414_ADDR_WR = 8'hcc;
  localparam logic [7:0] CUBE0414_DATA_WR = 8'hda;

  localparam int LAYER_NUM   = 8;
  localparam int ADDR_NUM    = 64;
  localparam int COLOR_NUM   = 3;
  localparam int FRAME_BYTES = LAYER_NUM * ADDR_NUM * COLOR_NUM;
  localparam int ADDR_BYTES  = ADDR_NUM;

  typedef enum logic {OP_DATA = 1'b0, OP_ADDR = 1'b1} cube_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } tx_state_t;

  function automatic logic [7:0] op_cmd(cube_op_t op);
    return (op == OP_ADDR) ? CUBE0414_ADDR_WR : CUBE0414_DATA_WR;
  endfunction

  function automatic logic [10:0] op_last_idx(cube_op_t op);
    return (op == OP_ADDR) ? 11'(ADDR_BYTES - 1) : 11'(FRAME_BYTES - 1);
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: SCLK divider, MSB-first shift register, bit counter.
// Chains bytes back-to-back while more_i is high at each byte boundary.
module spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic [7:0] next_data_i,
  input  logic       more_i,
  input  logic       clr_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       byte_req_o,
  output logic       last_bit_o
);

  localparam int DW = $clog2(CLK_DIV) + 1;

  logic [DW-1:0] div_q;
  logic          sclk_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_q;
  logic          active_q;
  logic          fall;

  assign fall       = active_q && (div_q == '0) && sclk_q;
  assign byte_req_o = fall && (bit_q == 3'd0);
  assign last_bit_o = fall && (bit_q == 3'd1);
  assign sclk_o     = sclk_q;
  assign mosi_o     = shreg_q[7];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q    <= '0;
      sclk_q   <= 1'b0;
      shreg_q  <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      div_q    <= DW'(CLK_DIV - 1);
      sclk_q   <= 1'b0;
      shreg_q  <= load_data_i;
      bit_q    <= 3'd7;
      active_q <= 1'b1;
    end else if (clr_i) begin
      shreg_q <= '0;
    end else if (active_q) begin
      if (div_q == '0) begin
        div_q <= DW'(CLK_DIV - 1);
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sclk_q <= 1'b0;
          // Byte boundary: chain the next byte or stop with the last bit held on MOSI.
          if (bit_q == 3'd0) begin
            if (more_i) begin
              shreg_q <= next_data_i;
              bit_q   <= 3'd7;
            end else begin
              active_q <= 1'b0;
            end
          end else begin
            shreg_q <= {shreg_q[6:0], 1'b0};
            bit_q   <= bit_q - 3'd1;
          end
        end
      end else begin
        div_q <= div_q - DW'(1);
      end
    end
  end

endmodule

// File: rtl/cube_frame_tx.sv
// CUBE0414 transaction sender: command byte (DC=0) then payload bytes (DC=1)
// prefetched from an external 1-cycle-latency byte RAM.
//
// state | meaning
// IDLE  | waiting for start_in; cs_n high
// SETUP | cs_n low, first bit on MOSI, waiting half a SCLK period
// SHIFT | bytes streaming back-to-back
// HOLD  | half SCLK period after the last fall, cs_n still low
// GAP   | cs_n high for a full SCLK period; done_out on the last cycle
module cube_frame_tx
  import cube0414_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        op_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        rd_en_out,
  output logic        rd_sel_out,
  output logic [10:0] rd_addr_out,
  input  logic [7:0]  rd_data_in,
  output logic        spi_sclk_out,
  output logic        spi_mosi_out,
  output logic        spi_cs_n_out,
  output logic        spi_dc_out
);

  localparam int TW = $clog2(2 * CLK_DIV) + 1;

  tx_state_t   state_q;
  cube_op_t    op_q;
  logic        busy_q, done_q, cs_n_q, dc_q, rd_en_q, cap_q;
  logic [10:0] rd_addr_q, cur_idx_q;
  logic [7:0]  next_byte_q;
  logic [TW-1:0] tmr_q;

  logic        load_d, clr_d, more_d, byte_req, last_bit;
  logic [7:0]  next_data_d;
  logic [10:0] last_idx_d;

  assign load_d      = (state_q == ST_IDLE) && start_in;
  assign clr_d       = (state_q == ST_HOLD) && (tmr_q == '0);
  assign last_idx_d  = op_last_idx(op_q);
  assign more_d      = !dc_q || (cur_idx_q != last_idx_d);
  // With CLK_DIV=1 the read returns on the very cycle the byte is consumed.
  assign next_data_d = cap_q ? rd_data_in : next_byte_q;

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_spi_byte_tx (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .load_i      (load_d),
    .load_data_i (op_cmd(cube_op_t'(op_in))),
    .next_data_i (next_data_d),
    .more_i      (more_d),
    .clr_i       (clr_d),
    .sclk_o      (spi_sclk_out),
    .mosi_o      (spi_mosi_out),
    .byte_req_o  (byte_req),
    .last_bit_o  (last_bit)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_DATA;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      dc_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      cap_q       <= 1'b0;
      rd_addr_q   <= '0;
      cur_idx_q   <= '0;
      next_byte_q <= '0;
      tmr_q       <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      cap_q   <= rd_en_q;
      if (cap_q) next_byte_q <= rd_data_in;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            op_q      <= cube_op_t'(op_in);
            busy_q    <= 1'b1;
            cs_n_q    <= 1'b0;
            dc_q      <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            cur_idx_q <= '0;
            tmr_q     <= TW'(CLK_DIV - 1);
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_q == '0) state_q <= ST_SHIFT;
          else             tmr_q   <= tmr_q - TW'(1);
        end
        ST_SHIFT: begin
          if (last_bit && dc_q && (cur_idx_q != last_idx_d)) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= cur_idx_q + 11'd1;
          end
          if (byte_req) begin
            if (!dc_q) begin
              dc_q      <= 1'b1;
              cur_idx_q <= '0;
            end else if (cur_idx_q != last_idx_d) begin
              cur_idx_q <= cur_idx_q + 11'd1;
            end else begin
              tmr_q   <= TW'(CLK_DIV - 1);
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (tmr_q == '0) begin
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            tmr_q   <= TW'(2 * CLK_DIV - 1);
            state_q <= ST_GAP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (tmr_q == TW'(1)) done_q <= 1'b1;
          if (tmr_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign rd_en_out    = rd_en_q;
  assign rd_sel_out   = op_q;
  assign rd_addr_out  = rd_addr_q;
  assign spi_cs_n_out = cs_n_q;
  assign spi_dc_out   = dc_q;

endmodule

// File: tb/tb_cube_frame_tx.sv
// Scoreboard bench: two DUT instances (CLK_DIV=2 and CLK_DIV=1) driven one at a time,
// observed by an SPI-slave monitor plus a cube receiver model.
module tb_cube_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [2];
  logic        op    [2];
  logic        busy  [2];
  logic        done  [2];
  logic        rd_en [2];
  logic        rd_sel[2];
  logic [10:0] rd_addr[2];
  logic [7:0]  rd_data[2];
  logic        sclk  [2];
  logic        mosi  [2];
  logic        cs_n  [2];
  logic        dc    [2];

  cube_frame_tx #(.CLK_DIV(2)) u_dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start[0]), .op_in(op[0]),
    .busy_out(busy[0]), .done_out(done[0]), .rd_en_out(rd_en[0]), .rd_sel_out(rd_sel[0]),
    .rd_addr_out(rd_addr[0]), .rd_data_in(rd_data[0]), .spi_sclk_out(sclk[0]),
    .spi_mosi_out(mosi[0]), .spi_cs_n_out(cs_n[0]), .spi_dc_out(dc[0]));

  cube_frame_tx #(.CLK_DIV(1)) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start[1]), .op_in(op[1]),
    .busy_out(busy[1]), .done_out(done[1]), .rd_en_out(rd_en[1]), .rd_sel_out(rd_sel[1]),
    .rd_addr_out(rd_addr[1]), .rd_data_in(rd_data[1]), .spi_sclk_out(sclk[1]),
    .spi_mosi_out(mosi[1]), .spi_cs_n_out(cs_n[1]), .spi_dc_out(dc[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // RAM model: data only valid on the cycle after a read strobe, junk otherwise.
  logic [7:0] frame_mem[1536];
  logic [7:0] addr_mem[64];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) rd_data[k] <= rd_sel[k] ? addr_mem[rd_addr[k][5:0]] : frame_mem[rd_addr[k]];
      else          rd_data[k] <= 8'($urandom);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  int         exp_len[$];
  int         exp_done = 0;

  bit sel = 0;
  logic cs_m, sclk_m, mosi_m, dc_m, done_m, rd_en_m, rd_sel_m;
  logic [10:0] rd_addr_m;
  always_comb begin
    cs_m      = sel ? cs_n[1]    : cs_n[0];
    sclk_m    = sel ? sclk[1]    : sclk[0];
    mosi_m    = sel ? mosi[1]    : mosi[0];
    dc_m      = sel ? dc[1]      : dc[0];
    done_m    = sel ? done[1]    : done[0];
    rd_en_m   = sel ? rd_en[1]   : rd_en[0];
    rd_sel_m  = sel ? rd_sel[1]  : rd_sel[0];
    rd_addr_m = sel ? rd_addr[1] : rd_addr[0];
  end

  // SPI slave + receiver model
  logic [7:0] rx_frame[8][64][3];
  logic [7:0] rx_cmd;
  int rdy_cnt = 0, done_cnt = 0, txn_bytes = 0;
  int rises = 0, nb = 0, last_rise = 0, cs_rise_cyc = -1000;
  bit have_rise = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    int cd, idx;
    logic [8:0] e;
    cd = sel ? 1 : 2;
    if (done_m === 1'b1) done_cnt++;
    if (!rst_n) begin
      nb = 0; rises = 0; have_rise = 0;
    end else begin
      if (rd_en_m) chk("rd_addr_range", {31'b0, rd_addr_m > (rd_sel_m ? 11'd63 : 11'd1535)}, 0);
      if (cs_prev && !cs_m) begin
        chk("cs_gap_ok", {31'b0, (cyc - cs_rise_cyc) >= 2 * cd}, 1);
        txn_bytes = 0; rises = 0; nb = 0; have_rise = 0;
      end
      if (!cs_m && sclk_m && !sclk_prev) begin
        rises++;
        if (have_rise) chk("sclk_period", cyc - last_rise, 2 * cd);
        have_rise = 1; last_rise = cyc;
        sh = {sh[6:0], mosi_m};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {23'b0, dc_m, sh}, 32'h1ff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("spi_byte", {23'b0, dc_m, sh}, {23'b0, e});
          end
          if (txn_bytes == 0) rx_cmd = sh;
          else if (rx_cmd == 8'hda && txn_bytes <= 1536) begin
            idx = txn_bytes - 1;
            rx_frame[7 - idx / 192][(idx % 192) / 3][idx % 3] = sh;
            if (idx == 1535) rdy_cnt++;
          end
          txn_bytes++;
        end
      end
      if (!cs_prev && cs_m) begin
        if (exp_len.size() == 0) chk("len_missing", rises, 32'hffff_ffff);
        else                     chk("sclk_rises", rises, exp_len.pop_front());
        have_rise = 0;
      end
    end
    if (!cs_prev && cs_m) cs_rise_cyc = cyc;
    cs_prev = cs_m;
    sclk_prev = sclk_m;
  end

  // Called #1 after a rising edge; returns #1 after the T+1 edge.
  task automatic start_op(input int k, input bit o);
    logic [7:0] c;
    int n;
    c = o ? 8'hcc : 8'hda;
    n = o ? 64 : 1536;
    start[k] = 1'b1;
    op[k] = o;
    exp_q.push_back({1'b0, c});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, o ? addr_mem[i] : frame_mem[i]});
    exp_len.push_back(8 * (n + 1));
    @(posedge clk); #1;
    start[k] = 1'b0;
    op[k] = 1'($urandom);
    chk("start_resp", {27'b0, busy[k], cs_n[k], dc[k], mosi[k], sclk[k]}, {27'b0, 1'b1, 1'b0, 1'b0, c[7], 1'b0});
  endtask

  // Returns #1 after the edge where busy should have fallen.
  task automatic finish_op(input int k, input int lim, input bit poke);
    int n;
    n = 0;
    while (done[k] !== 1'b1 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (done[k] !== 1'b1) begin
      chk("done_timeout", {31'b0, done[k]}, 1);
      return;
    end
    exp_done++;
    chk("busy_at_done", {30'b0, busy[k], cs_n[k]}, 3);
    if (poke) begin
      start[k] = 1'b1;
      op[k] = 1'($urandom);
    end
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk("busy_after_done", {29'b0, busy[k], done[k], cs_n[k]}, 1);
  endtask

  function automatic logic [31:0] outs(input int k);
    return {13'b0, cs_n[k], sclk[k], busy[k], done[k], rd_en[k], mosi[k], dc[k], rd_sel[k], rd_addr[k]};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin start[k] = 1'b0; op[k] = 1'b0; end
    for (int i = 0; i < 1536; i++) frame_mem[i] = 8'(i);
    for (int i = 0; i < 64; i++) addr_mem[i] = 8'(i);
    repeat (3) @(posedge clk); #1;
    chk("reset_dut2", outs(0), 32'h40000);
    chk("reset_dut1", outs(1), 32'h40000);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // ADDR op, stray start mid-transfer and on the done cycle
    start_op(0, 1'b1);
    repeat (200 + $urandom_range(0, 200)) @(posedge clk);
    #1; start[0] = 1'b1; op[0] = 1'($urandom);
    @(posedge clk); #1; start[0] = 1'b0;
    chk("start_mid_ignored", {31'b0, busy[0]}, 1);
    finish_op(0, 2500, 1'b1);
    chk("rd_addr_end_addr", rd_addr[0], 63);

    // start right after busy falls, random table
    for (int i = 0; i < 64; i++) addr_mem[i] = 8'($urandom);
    start_op(0, 1'b1);
    finish_op(0, 2500, 1'b0);
    chk("rd_addr_end_addr2", rd_addr[0], 63);

    repeat (5) @(posedge clk); #1;
    sel = 1;
    repeat (3) @(posedge clk); #1;

    // CLK_DIV=1 DATA op, then back-to-back DATA op aborted by reset
    start_op(1, 1'b0);
    finish_op(1, 25000, 1'b0);
    chk("rd_addr_end_data", rd_addr[1], 1535);
    chk("rx_rdy1", rdy_cnt, 1);
    chk("rx_l7a0", {8'b0, rx_frame[7][0][0], rx_frame[7][0][1], rx_frame[7][0][2]}, 32'h000102);

    start_op(1, 1'b0);
    repeat (2) @(posedge clk);
    n = 0;
    while (txn_bytes < 101 && n < 5000) begin @(posedge clk); n++; end
    #1;
    chk("byte100_reached", {31'b0, txn_bytes >= 101}, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_txn", outs(1), 32'h40000);
    exp_q.delete();
    exp_len.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 1536; i++) frame_mem[i] = 8'($urandom);
    repeat (2) @(posedge clk); #1;
    start_op(1, 1'b0);
    finish_op(1, 25000, 1'b0);
    chk("rd_addr_end_data2", rd_addr[1], 1535);
    chk("rx_rdy2", rdy_cnt, 2);
    chk("rx_first", {24'b0, rx_frame[7][0][0]}, {24'b0, frame_mem[0]});
    chk("rx_last", {24'b0, rx_frame[0][63][2]}, {24'b0, frame_mem[1535]});

    repeat (4) @(posedge clk); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_pulses", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
